train_main_ctrl: RTL

- Main sequencer for the training top.
- Decodes the software control bits (next/set/run/rst_n, mode) and drives the compute phases in order: forward chain (emb→mix→comp→softmax), backward chain, parameter update.
- Covers one batch of BATCH_SIZE samples per run.
- Exposes state_main and the finish flag for the AXI-Lite status register. Sits between the AXI-Lite register file and the layer datapaths.

---
 rtl/train_main_ctrl_pkg.sv | 21 ++
 rtl/train_main_ctrl_edge_det.sv | 37 +++
 rtl/train_main_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/train_main_ctrl_pkg.sv
// Shared constants for the training main sequencer.
// - State codes for state_main (3-bit encoding shared with the status register).
// - Mode field values decoded from slv_reg1.
package train_main_ctrl_pkg;

  localparam int unsigned StateMainLen = 3;

  typedef logic [StateMainLen-1:0] state_main_t;

  // Kept as plain constants so other blocks and software can share the numeric encoding.
  localparam state_main_t M_WAIT = 3'd0;
  localparam state_main_t M_SET  = 3'd1;
  localparam state_main_t M_FWD  = 3'd2;
  localparam state_main_t M_BWD  = 3'd3;
  localparam state_main_t M_UPD  = 3'd4;
  localparam state_main_t M_FIN  = 3'd5;

  localparam int unsigned ModeForward = 0;
  localparam int unsigned ModeTrain   = 1;

endpackage

// File: rtl/train_main_ctrl_edge_det.sv
// Registered rising-edge detector for one software control bit.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear (soft reset), active high
//   x           - level input from the register file
//   rise        - high for the cycle in which x is seen going low->high
module train_main_ctrl_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic x,
  output logic rise
);

  logic x_q, x_d;
  logic armed_q, armed_d;

  always_comb begin
    x_d     = clr ? 1'b0 : x;
    armed_d = ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      armed_q <= armed_d;
    end
  end

  // The first cycle after any reset only samples the level, so a bit already held high
  // across reset is not mistaken for a fresh rising edge.
  assign rise = armed_q & x & ~x_q;

endmodule

// File: rtl/train_main_ctrl.sv
// Main sequencer for the training top.
// Decodes software control bits and runs forward -> backward -> update over one batch.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   soft_rst_n         - synchronous clear, overrides everything else
//   run, set, next     - software level bits, acted on at their rising edge
//   mode_in            - FORWARD or TRAIN, latched on set
//   fwd/bwd/upd_valid  - layer completion pulses
//   fwd/bwd/upd_run    - layer start pulses (registered)
//   out_wr             - commit current forward result to the output stream buffer
//   batch_cnt          - index of the sample in flight
//   mode_q             - latched mode
//   state_main, finish - status register fields
module train_main_ctrl
  import train_main_ctrl_pkg::*;
#(
  parameter int unsigned BATCH_SIZE = 4,
  parameter int unsigned MODE_LEN   = 2,
  parameter int unsigned CNT_W      = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                soft_rst_n,
  input  logic                run,
  input  logic                set,
  input  logic                next,
  input  logic [MODE_LEN-1:0] mode_in,
  input  logic                fwd_valid,
  input  logic                bwd_valid,
  input  logic                upd_valid,
  output logic                fwd_run,
  output logic                bwd_run,
  output logic                upd_run,
  output logic                out_wr,
  output logic [CNT_W-1:0]    batch_cnt,
  output logic [MODE_LEN-1:0] mode_q,
  output logic [2:0]          state_main,
  output logic                finish
);

  localparam logic [MODE_LEN-1:0] ModeTrainV = MODE_LEN'(ModeTrain);
  localparam logic [CNT_W-1:0]    LastIdx    = CNT_W'(BATCH_SIZE - 1);

  logic rise_run, rise_set, rise_next;
  logic clr;

  assign clr = ~soft_rst_n;

  train_main_ctrl_edge_det u_edge_run (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .x    (run),
    .rise (rise_run)
  );

  train_main_ctrl_edge_det u_edge_set (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .x    (set),
    .rise (rise_set)
  );

  train_main_ctrl_edge_det u_edge_next (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .x    (next),
    .rise (rise_next)
  );

  state_main_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MODE_LEN-1:0] mode_lat_q, mode_lat_d;
  logic                finish_q, finish_d;
  logic                fwd_run_q, fwd_run_d;
  logic                bwd_run_q, bwd_run_d;
  logic                upd_run_q, upd_run_d;
  logic                out_wr_q, out_wr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_lat_d = mode_lat_q;
    finish_d   = finish_q;
    fwd_run_d  = 1'b0;
    bwd_run_d  = 1'b0;
    upd_run_d  = 1'b0;
    out_wr_d   = 1'b0;

    if (!soft_rst_n) begin
      state_d    = M_WAIT;
      cnt_d      = '0;
      mode_lat_d = '0;
      finish_d   = 1'b0;
    end else begin
      // Rises are tested in priority order next > set > run; losers are simply dropped.
      case (state_q)
        M_WAIT: begin
          if (rise_next) begin
            cnt_d    = '0;
            finish_d = 1'b0;
          end else if (rise_set) begin
            mode_lat_d = mode_in;
            state_d    = M_SET;
          end
        end
        M_SET: begin
          if (rise_next) begin
            state_d = M_WAIT;
          end else if (rise_set) begin
            mode_lat_d = mode_in;
          end else if (rise_run) begin
            fwd_run_d = 1'b1;
            state_d   = M_FWD;
          end
        end
        M_FWD: begin
          if (fwd_valid) begin
            out_wr_d = 1'b1;
            // Unknown mode codes fall through to the FORWARD path.
            if (mode_lat_q == ModeTrainV) begin
              bwd_run_d = 1'b1;
              state_d   = M_BWD;
            end else begin
              finish_d = 1'b1;
              state_d  = M_FIN;
            end
          end
        end
        M_BWD: begin
          if (bwd_valid) begin
            if (cnt_q < LastIdx) begin
              cnt_d     = cnt_q + CNT_W'(1);
              fwd_run_d = 1'b1;
              state_d   = M_FWD;
            end else begin
              upd_run_d = 1'b1;
              state_d   = M_UPD;
            end
          end
        end
        M_UPD: begin
          if (upd_valid) begin
            finish_d = 1'b1;
            state_d  = M_FIN;
          end
        end
        M_FIN: begin
          if (rise_next) begin
            finish_d = 1'b0;
            cnt_d    = '0;
            state_d  = M_WAIT;
          end
        end
        default: begin
          state_d = M_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= M_WAIT;
      cnt_q      <= '0;
      mode_lat_q <= '0;
      finish_q   <= 1'b0;
      fwd_run_q  <= 1'b0;
      bwd_run_q  <= 1'b0;
      upd_run_q  <= 1'b0;
      out_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_lat_q <= mode_lat_d;
      finish_q   <= finish_d;
      fwd_run_q  <= fwd_run_d;
      bwd_run_q  <= bwd_run_d;
      upd_run_q  <= upd_run_d;
      out_wr_q   <= out_wr_d;
    end
  end

  assign fwd_run    = fwd_run_q;
  assign bwd_run    = bwd_run_q;
  assign upd_run    = upd_run_q;
  assign out_wr     = out_wr_q;
  assign batch_cnt  = cnt_q;
  assign mode_q     = mode_lat_q;
  assign state_main = state_q;
  assign finish     = finish_q;

endmodule
